// File: rtl/long_inst_wb_arb.sv
// Long-latency result writeback arbiter: per-source holding registers, round-robin onto one RF write port.
// Optional duplicate commit-ID detection is built when LONG_WB_ID_CHECK_EN is defined.
`timescale 1ns/1ps
`ifndef COMMIT_ID_WIDTH
  `define COMMIT_ID_WIDTH 4
`endif
`ifndef REG_ADDR_WIDTH
  `define REG_ADDR_WIDTH 5
`endif

module long_inst_wb_arb #(
  parameter int NUM_SRC    = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_SRC-1:0]                    src_valid_i,
  output logic [NUM_SRC-1:0]                    src_ready_o,
  input  logic [NUM_SRC*`REG_ADDR_WIDTH-1:0]    src_rd_addr_i,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]         src_data_i,
  input  logic [NUM_SRC*`COMMIT_ID_WIDTH-1:0]   src_commit_id_i,
  input  logic                                  short_wb_busy_i,
  output logic                                  reg_we_o,
  output logic [`REG_ADDR_WIDTH-1:0]            reg_waddr_o,
  output logic [DATA_WIDTH-1:0]                 reg_wdata_o,
  output logic                                  commit_valid_o,
  output logic [`COMMIT_ID_WIDTH-1:0]           commit_id_o,
  output logic                                  id_conflict_o
);
  localparam int RW = `REG_ADDR_WIDTH;
  localparam int IW = `COMMIT_ID_WIDTH;
  localparam int PW = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]                 hold_valid;
  logic [NUM_SRC-1:0][RW-1:0]         hold_rd;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0] hold_data;
  logic [NUM_SRC-1:0][IW-1:0]         hold_id;

  logic [PW-1:0]      ptr;
  logic [PW-1:0]      cand;
  logic [PW-1:0]      gnt_idx;
  logic               gnt_any;
  logic [NUM_SRC-1:0] grant;

  // Search starts one past the last winner so every source is reached within NUM_SRC grants.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (!short_wb_busy_i) begin
      for (int k = 1; k <= NUM_SRC; k++) begin
        cand = PW'((int'(ptr) + k) % NUM_SRC);
        if (!gnt_any && hold_valid[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    if (gnt_any) grant[gnt_idx] = 1'b1;
  end

  // Ready includes the grant so a draining entry can refill in the same cycle.
  assign src_ready_o = ~hold_valid | grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= '0;
      hold_rd    <= '0;
      hold_data  <= '0;
      hold_id    <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_valid_i[i] && src_ready_o[i]) begin
          hold_valid[i] <= 1'b1;
          hold_rd[i]    <= src_rd_addr_i[i*RW +: RW];
          hold_data[i]  <= src_data_i[i*DATA_WIDTH +: DATA_WIDTH];
          hold_id[i]    <= src_commit_id_i[i*IW +: IW];
        end else if (grant[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr            <= PW'(NUM_SRC - 1);
      commit_valid_o <= 1'b0;
      reg_we_o       <= 1'b0;
      commit_id_o    <= '0;
      reg_waddr_o    <= '0;
      reg_wdata_o    <= '0;
    end else if (gnt_any) begin
      ptr            <= gnt_idx;
      commit_valid_o <= 1'b1;
      reg_we_o       <= (hold_rd[gnt_idx] != '0);
      commit_id_o    <= hold_id[gnt_idx];
      reg_waddr_o    <= hold_rd[gnt_idx];
      reg_wdata_o    <= hold_data[gnt_idx];
    end else begin
      commit_valid_o <= 1'b0;
      reg_we_o       <= 1'b0;
    end
  end

`ifdef LONG_WB_ID_CHECK_EN
  logic dup;

  // A live ID may appear only once across the holding entries and the retiring output.
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int j = i + 1; j < NUM_SRC; j++)
        if (hold_valid[i] && hold_valid[j] && (hold_id[i] == hold_id[j])) dup = 1'b1;
      if (commit_valid_o && hold_valid[i] && (hold_id[i] == commit_id_o)) dup = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) id_conflict_o <= 1'b0;
    else        id_conflict_o <= id_conflict_o | dup;
  end
`else
  assign id_conflict_o = 1'b0;
`endif

endmodule

// File: tb/tb_long_inst_wb_arb.sv
// Randomized and directed bench for long_inst_wb_arb against a per-source holding/scoreboard model.
`timescale 1ns/1ps
`ifndef COMMIT_ID_WIDTH
  `define COMMIT_ID_WIDTH 4
`endif
`ifndef REG_ADDR_WIDTH
  `define REG_ADDR_WIDTH 5
`endif

module tb_long_inst_wb_arb;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int RW = `REG_ADDR_WIDTH;
  localparam int IW = `COMMIT_ID_WIDTH;
`ifdef LONG_WB_ID_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]    src_valid_i = '0;
  logic [N-1:0]    src_ready_o;
  logic [N*RW-1:0] src_rd_addr_i = '0;
  logic [N*DW-1:0] src_data_i = '0;
  logic [N*IW-1:0] src_commit_id_i = '0;
  logic            short_wb_busy_i = 1'b0;
  logic            reg_we_o;
  logic [RW-1:0]   reg_waddr_o;
  logic [DW-1:0]   reg_wdata_o;
  logic            commit_valid_o;
  logic [IW-1:0]   commit_id_o;
  logic            id_conflict_o;

  always #5 clk = ~clk;

  long_inst_wb_arb #(.NUM_SRC(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
    .src_rd_addr_i(src_rd_addr_i), .src_data_i(src_data_i), .src_commit_id_i(src_commit_id_i),
    .short_wb_busy_i(short_wb_busy_i),
    .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
    .commit_valid_o(commit_valid_o), .commit_id_o(commit_id_o), .id_conflict_o(id_conflict_o)
  );

  typedef struct packed {
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
    logic [IW-1:0] id;
  } txn_t;

  txn_t q [N][$];          // results waiting at each source
  bit   m_full [N];        // model: source result parked, not yet retired
  txn_t m_ent  [N];
  int   m_last;            // source retired most recently
  bit            e_cv, e_we, e_conf;
  logic [IW-1:0] e_id;
  logic [RW-1:0] e_addr;
  logic [DW-1:0] e_data;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic int model_pick();
    if (short_wb_busy_i) return -1;
    for (int k = 1; k <= N; k++)
      if (m_full[(m_last + k) % N]) return (m_last + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    int g;
    g = model_pick();
    for (int i = 0; i < N; i++) r[i] = !m_full[i] || (g == i);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_full[i] = 0; m_ent[i] = '0; end
    m_last = N - 1;
    e_cv = 0; e_we = 0; e_conf = 0; e_id = '0; e_addr = '0; e_data = '0;
  endtask

  task automatic model_step();
    int g;
    logic [N-1:0] rdy;
    g   = model_pick();
    rdy = model_ready();
    if (CHK) begin
      for (int i = 0; i < N; i++) begin
        if (m_full[i] && e_cv && m_ent[i].id == e_id) e_conf = 1;
        for (int j = 0; j < N; j++)
          if (i != j && m_full[i] && m_full[j] && m_ent[i].id == m_ent[j].id) e_conf = 1;
      end
    end
    if (g >= 0) begin
      e_cv = 1; e_id = m_ent[g].id; e_addr = m_ent[g].rd; e_data = m_ent[g].data;
      e_we = (m_ent[g].rd != 0);
      m_last = g;
      m_full[g] = 0;
    end else begin
      e_cv = 0; e_we = 0;
    end
    for (int i = 0; i < N; i++)
      if (src_valid_i[i] && rdy[i]) begin
        m_full[i] = 1;
        m_ent[i]  = q[i].pop_front();
      end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0) begin
        src_valid_i[i] = 1'b1;
        src_rd_addr_i[i*RW +: RW]   = q[i][0].rd;
        src_data_i[i*DW +: DW]      = q[i][0].data;
        src_commit_id_i[i*IW +: IW] = q[i][0].id;
      end else begin
        src_valid_i[i] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1 drive();
    @(negedge clk);
  endtask

  task automatic push(input int s, input logic [RW-1:0] rd, input logic [DW-1:0] d, input logic [IW-1:0] id);
    txn_t t;
    t.rd = rd; t.data = d; t.id = id;
    q[s].push_back(t);
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    short_wb_busy_i = 1'b0;
    for (int i = 0; i < N; i++) q[i].delete();
    model_reset();
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests += 7;
    if (commit_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_cv got=%b exp=0", commit_valid_o); end
    if (reg_we_o !== 1'b0)       begin n_fail++; $display("FAIL reset_we got=%b exp=0", reg_we_o); end
    if (reg_waddr_o !== '0)      begin n_fail++; $display("FAIL reset_waddr got=%0d exp=0", reg_waddr_o); end
    if (reg_wdata_o !== '0)      begin n_fail++; $display("FAIL reset_wdata got=%h exp=0", reg_wdata_o); end
    if (commit_id_o !== '0)      begin n_fail++; $display("FAIL reset_id got=%0d exp=0", commit_id_o); end
    if (id_conflict_o !== 1'b0)  begin n_fail++; $display("FAIL reset_conflict got=%b exp=0", id_conflict_o); end
    if (src_ready_o !== 3'b111)  begin n_fail++; $display("FAIL reset_ready got=%b exp=111", src_ready_o); end
  endtask

  task automatic test_single();
    push(1, 5'd5, 32'hDEADBEEF, 4'd2);
    tick();
    n_tests++;
    if (commit_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_early got=%b exp=0", commit_valid_o); end
    tick();
    n_tests += 5;
    if (commit_valid_o !== 1'b1)      begin n_fail++; $display("FAIL single_cv got=%b exp=1", commit_valid_o); end
    if (commit_id_o !== 4'd2)         begin n_fail++; $display("FAIL single_id got=%0d exp=2", commit_id_o); end
    if (reg_we_o !== 1'b1)            begin n_fail++; $display("FAIL single_we got=%b exp=1", reg_we_o); end
    if (reg_waddr_o !== 5'd5)         begin n_fail++; $display("FAIL single_waddr got=%0d exp=5", reg_waddr_o); end
    if (reg_wdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_wdata got=%h exp=deadbeef", reg_wdata_o); end
    tick();
    n_tests += 3;
    if (commit_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_after_cv got=%b exp=0", commit_valid_o); end
    if (reg_we_o !== 1'b0)       begin n_fail++; $display("FAIL single_after_we got=%b exp=0", reg_we_o); end
    if (reg_waddr_o !== 5'd5)    begin n_fail++; $display("FAIL single_hold_waddr got=%0d exp=5", reg_waddr_o); end
  endtask

  task automatic test_round_robin();
    int got [$];
    int at  [$];
    int exp_ids [6] = '{0, 1, 2, 4, 5, 6};
    do_reset();
    for (int s = 0; s < N; s++) push(s, RW'(s + 1), DW'($urandom), IW'(s));
    for (int s = 0; s < N; s++) push(s, RW'(s + 10), DW'($urandom), IW'(s + 4));
    for (int c = 0; c < 20; c++) begin
      tick();
      if (commit_valid_o === 1'b1) begin got.push_back(int'(commit_id_o)); at.push_back(c); end
    end
    n_tests++;
    if (got.size() != 6) begin
      n_fail++; $display("FAIL rr_count got=%0d exp=6", got.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_tests += 2;
        if (got[k] != exp_ids[k]) begin n_fail++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", k, got[k], exp_ids[k]); end
        if (at[k] != at[0] + k)   begin n_fail++; $display("FAIL rr_gap[%0d] got=%0d exp=%0d", k, at[k], at[0] + k); end
      end
    end
  endtask

  task automatic test_busy();
    do_reset();
    short_wb_busy_i = 1'b1;
    push(0, 5'd7, 32'h1111_0000, 4'd5);
    push(2, 5'd9, 32'h2222_0000, 4'd6);
    tick();
    for (int c = 0; c < 4; c++) begin
      tick();
      n_tests += 3;
      if (commit_valid_o !== 1'b0) begin n_fail++; $display("FAIL busy_cv c%0d got=%b exp=0", c, commit_valid_o); end
      if (src_ready_o[0] !== 1'b0) begin n_fail++; $display("FAIL busy_ready0 c%0d got=%b exp=0", c, src_ready_o[0]); end
      if (src_ready_o[2] !== 1'b0) begin n_fail++; $display("FAIL busy_ready2 c%0d got=%b exp=0", c, src_ready_o[2]); end
    end
    short_wb_busy_i = 1'b0;
    tick();
    n_tests += 2;
    if (commit_valid_o !== 1'b1 || commit_id_o !== 4'd5)
      begin n_fail++; $display("FAIL busy_rel0 got=%b/%0d exp=1/5", commit_valid_o, commit_id_o); end
    if (reg_wdata_o !== 32'h1111_0000) begin n_fail++; $display("FAIL busy_rel0_data got=%h exp=11110000", reg_wdata_o); end
    tick();
    n_tests += 2;
    if (commit_valid_o !== 1'b1 || commit_id_o !== 4'd6)
      begin n_fail++; $display("FAIL busy_rel1 got=%b/%0d exp=1/6", commit_valid_o, commit_id_o); end
    if (reg_waddr_o !== 5'd9) begin n_fail++; $display("FAIL busy_rel1_addr got=%0d exp=9", reg_waddr_o); end
  endtask

  task automatic test_x0();
    push(1, 5'd0, 32'hCAFE_F00D, 4'd3);
    tick();
    tick();
    n_tests += 3;
    if (commit_valid_o !== 1'b1) begin n_fail++; $display("FAIL x0_cv got=%b exp=1", commit_valid_o); end
    if (commit_id_o !== 4'd3)    begin n_fail++; $display("FAIL x0_id got=%0d exp=3", commit_id_o); end
    if (reg_we_o !== 1'b0)       begin n_fail++; $display("FAIL x0_we got=%b exp=0", reg_we_o); end
  endtask

  task automatic test_conflict();
    do_reset();
    short_wb_busy_i = 1'b1;
    push(0, 5'd1, 32'hA, 4'd1);
    push(1, 5'd2, 32'hB, 4'd1);
    tick();
    tick();
    n_tests++;
    if (id_conflict_o !== CHK) begin n_fail++; $display("FAIL conflict_set got=%b exp=%b", id_conflict_o, CHK); end
    repeat (10) tick();
    n_tests++;
    if (id_conflict_o !== CHK) begin n_fail++; $display("FAIL conflict_sticky got=%b exp=%b", id_conflict_o, CHK); end
    short_wb_busy_i = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_random();
    bit done;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s < N; s++)
        if (q[s].size() < 3 && $urandom_range(0, 2) == 0)
          push(s, RW'($urandom_range(0, 31)), DW'($urandom), IW'($urandom_range(0, 15)));
      short_wb_busy_i = ($urandom_range(0, 3) == 0);
      tick();
      n_tests += 7;
      if (commit_valid_o !== e_cv)   begin n_fail++; $display("FAIL rnd_cv c%0d got=%b exp=%b", c, commit_valid_o, e_cv); end
      if (reg_we_o !== e_we)         begin n_fail++; $display("FAIL rnd_we c%0d got=%b exp=%b", c, reg_we_o, e_we); end
      if (commit_id_o !== e_id)      begin n_fail++; $display("FAIL rnd_id c%0d got=%0d exp=%0d", c, commit_id_o, e_id); end
      if (reg_waddr_o !== e_addr)    begin n_fail++; $display("FAIL rnd_waddr c%0d got=%0d exp=%0d", c, reg_waddr_o, e_addr); end
      if (reg_wdata_o !== e_data)    begin n_fail++; $display("FAIL rnd_wdata c%0d got=%h exp=%h", c, reg_wdata_o, e_data); end
      if (src_ready_o !== model_ready()) begin n_fail++; $display("FAIL rnd_ready c%0d got=%b exp=%b", c, src_ready_o, model_ready()); end
      if (id_conflict_o !== e_conf)  begin n_fail++; $display("FAIL rnd_conflict c%0d got=%b exp=%b", c, id_conflict_o, e_conf); end
    end
    short_wb_busy_i = 1'b0;
    done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      tick();
      done = 1;
      for (int s = 0; s < N; s++) if (q[s].size() != 0 || m_full[s]) done = 0;
    end
    n_tests++;
    if (!done) begin n_fail++; $display("FAIL rnd_drain timeout got=pending exp=empty"); end
    tick();
    n_tests++;
    if (src_ready_o !== 3'b111) begin n_fail++; $display("FAIL rnd_final_ready got=%b exp=111", src_ready_o); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_x0();
    test_round_robin();
    test_busy();
    test_conflict();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/long_inst_wb_arb.md
Name: long_inst_wb_arb

Overview:
- Completion-side counterpart of the long-instruction hazard/ID allocator.
- Collects results from NUM_SRC long-latency units (e.g. mul, div, lsu), each tagged with the commit ID assigned at issue.
- Buffers each result in a per-source holding register and arbitrates round-robin onto the single long-path register-file write port.
- Emits one commit_valid_o/commit_id_o pulse per retired result so the allocator frees that ID.

Parameters:
- NUM_SRC, 3, number of long-latency result sources (2..8).
- DATA_WIDTH, 32, result data width.
- (`COMMIT_ID_WIDTH and `REG_ADDR_WIDTH come from defines.svh.)

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous reset, active low
- src_valid_i  input  NUM_SRC  result valid per source
- src_ready_o  output  NUM_SRC  holding register can accept per source
- src_rd_addr_i  input  NUM_SRC*`REG_ADDR_WIDTH  destination register, source i at slice i
- src_data_i  input  NUM_SRC*DATA_WIDTH  result data, source i at slice i
- src_commit_id_i  input  NUM_SRC*`COMMIT_ID_WIDTH  commit ID, source i at slice i
- short_wb_busy_i  input  1  short-path writeback owns the register-file port this cycle
- reg_we_o  output  1  register-file write enable
- reg_waddr_o  output  `REG_ADDR_WIDTH  write address
- reg_wdata_o  output  DATA_WIDTH  write data
- commit_valid_o  output  1  long instruction retired
- commit_id_o  output  `COMMIT_ID_WIDTH  ID of the retired instruction
- id_conflict_o  output  1  sticky duplicate-ID error (see Optional Feature)

Behaviour:
- Reset (async, rst_n low):
  - All hold_valid cleared; pending results are discarded.
  - All outputs 0.
  - Round-robin pointer set to NUM_SRC-1, so source 0 has first priority.
- Holding registers: one entry per source with fields valid, rd, data, id.
  - src_ready_o[i] = ~hold_valid[i] | grant[i]. This is combinational, so a granted entry refills in the same cycle.
  - On valid&ready the entry captures rd, data and id at the clock edge.
- Arbitration (combinational, registered stage):
  - No grant when short_wb_busy_i=1. Pointer is unchanged in that case.
  - Otherwise grant the first hold_valid index found from (ptr+1) mod NUM_SRC upward, with wrap-around.
  - At most one grant per cycle.
  - On a grant, the pointer takes the granted index and hold_valid[g] clears unless the same source refills in that cycle.
- Output register:
  - The cycle after a grant: commit_valid_o=1, commit_id_o=hold.id, reg_waddr_o=hold.rd, reg_wdata_o=hold.data.
  - reg_we_o = (hold.rd != 0). For rd=x0 the commit still pulses so the ID is freed, but no write occurs.
  - With no grant, commit_valid_o=0 and reg_we_o=0. Address, data and ID outputs hold their last values.
- Latency: source handshake at edge N -> grant in cycle N+1 -> outputs valid for one cycle after edge N+1. Minimum 2 cycles.
- Throughput: one retire per cycle, including back-to-back from a single source.
- Simultaneous valid from all sources: retired in rotating order, and each source is served within NUM_SRC grants (no starvation).
- short_wb_busy_i held high: holding registers stay full, src_ready_o=0 for full entries, and no data is lost.
- IDs are not reordered or checked by default. Uniqueness is guaranteed by the allocator.

Optional Feature:
- Macro: LONG_WB_ID_CHECK_EN.
- Defined: each cycle, compare IDs of all valid holding entries pairwise and against the ID being output.
  - Any match sets id_conflict_o at the next edge.
  - id_conflict_o stays set until reset.
- Undefined: id_conflict_o is tied 0 and no comparators are built.

Test Plan:
- Reset behaviour: rst_n low, then high. Check all outputs 0 and src_ready_o=all ones.
- Single-source latency: source 1 sends rd=5, data=0xDEADBEEF, id=2 at edge N. Check commit_valid_o=1, commit_id_o=2, reg_we_o=1, reg_waddr_o=5, reg_wdata_o=0xDEADBEEF exactly one cycle after edge N+1, then 0.
- Round-robin order: sources 0,1,2 valid in the same cycle with ids 0,1,2. Check commits ids 0,1,2 on consecutive cycles. Repeat immediately and check order continues 0,1,2 with no source skipped.
- Port contention: short_wb_busy_i=1 for 4 cycles with sources 0 and 2 pending. Check no commit, src_ready_o[0]=src_ready_o[2]=0. After release, check ids emitted on the next two cycles.
- x0 destination: rd=0, id=3. Check commit_valid_o=1, commit_id_o=3, reg_we_o=0.
- Duplicate ID (macro defined): sources 0 and 1 both hold id=1. Check id_conflict_o=1 next cycle and still 1 after 10 cycles. With the macro undefined, check it stays 0.
